// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// Executes MULT, MULTU, DIV, DIVU (one bit per cycle over WIDTH cycles,
// followed by a sign-fix cycle) and MTHI/MTLO (single-cycle register writes).
// stall holds the control decoder in its execute state until HI/LO carry the
// new result; the result is visible from the first cycle stall is low again.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] COUNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e             state_q,  state_d;
  logic [CW-1:0]      counter_q, counter_d;
  // Magnitude of SrcA; constant for the whole operation (multiplicand, or the
  // source for rebuilding SrcA on a divide by zero).
  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  // Magnitude of SrcB; shifted right each RUN cycle for multiply, held as the
  // divisor for divide.
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q,   prod_d;
  logic [WIDTH:0]     rem_q,    rem_d;
  logic [WIDTH-1:0]   quot_q,   quot_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   hi_q,     hi_d;
  logic [WIDTH-1:0]   lo_q,     lo_d;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic             is_muldiv_op;
  logic             is_signed_op;
  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign is_muldiv_op = (op == OP_MULT) || (op == OP_MULTU) ||
                        (op == OP_DIV)  || (op == OP_DIVU);
  assign is_signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign accept       = (state_q == S_IDLE) && start && is_muldiv_op;
  assign a_neg        = is_signed_op && SrcA[WIDTH-1];
  assign b_neg        = is_signed_op && SrcB[WIDTH-1];
  assign a_mag        = a_neg ? (~SrcA + 1'b1) : SrcA;
  assign b_mag        = b_neg ? (~SrcB + 1'b1) : SrcB;

  // ---------------------------------------------------------------------------
  // One iteration of each algorithm
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_fits;

  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right by one.
  assign mul_addend = mplier_q[0] ? mcand_q : '0;
  assign mul_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, prod_q[WIDTH-1:1]};

  // Restoring divide: bring the next dividend bit into the partial remainder
  // and subtract the divisor; keep the difference only if it did not borrow.
  assign div_shift  = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
  assign div_diff   = {1'b0, div_shift} - {2'b00, mplier_q};
  assign div_fits   = ~div_diff[WIDTH+1];

  // ---------------------------------------------------------------------------
  // Final sign correction, applied in FIX
  // ---------------------------------------------------------------------------
  logic               res_neg;
  logic               div_by_zero;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   a_orig;

  // Sign flags are only ever set for signed ops, so unsigned results pass
  // through untouched. The most-negative overflow case needs no special
  // handling: its magnitude quotient negates back to itself.
  assign res_neg     = sign_a_q ^ sign_b_q;
  assign div_by_zero = (mplier_q == '0);
  assign prod_fix    = res_neg  ? (~prod_q + 1'b1) : prod_q;
  assign quot_fix    = res_neg  ? (~quot_q + 1'b1) : quot_q;
  assign rem_fix     = sign_a_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
  assign a_orig      = sign_a_q ? (~mcand_q + 1'b1) : mcand_q;

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all flops
  // sample their _d values from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept -> WIDTH RUN cycles -> FIX -> DONE -> IDLE.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no
    // latch is inferred for combinational outputs.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_RUN;
      S_RUN:  if (counter_q == '0) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: stall rises combinationally on the accept cycle and stays
  // high through RUN and FIX.
  always_comb begin
    stall = 1'b0;
    unique case (state_q)
      S_IDLE:  stall = accept;
      S_RUN:   stall = 1'b1;
      S_FIX:   stall = 1'b1;
      S_DONE:  stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  // Datapath next values: operand capture, iteration, and HI/LO writes.
  always_comb begin
    counter_d = counter_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          counter_d = COUNT_LOAD;
          mcand_d   = a_mag;
          mplier_d  = b_mag;
          sign_a_d  = a_neg;
          sign_b_d  = b_neg;
          is_div_d  = (op == OP_DIV) || (op == OP_DIVU);
          prod_d    = '0;
          rem_d     = '0;
          quot_d    = a_mag;
        end else if (start && (op == OP_MTHI)) begin
          hi_d = SrcA;
        end else if (start && (op == OP_MTLO)) begin
          lo_d = SrcA;
        end
      end

      S_RUN: begin
        counter_d = counter_q - CW'(1);
        if (is_div_q) begin
          rem_d  = div_fits ? div_diff[WIDTH:0] : div_shift;
          quot_d = {quot_q[WIDTH-2:0], div_fits};
        end else begin
          prod_d   = mul_next;
          mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        end
      end

      S_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (div_by_zero) begin
          hi_d = a_orig;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
      end

      S_DONE: begin
      end

      default: begin
      end
    endcase
  end

  // Datapath registers; reset clears everything, including an operation in
  // flight, so an aborted operation leaves HI/LO at zero.
  always_ff @(posedge clk) begin
    if (Rst) begin
      counter_q <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      is_div_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      counter_q <= counter_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32).
// Expected {hi,lo} pairs are queued when an operation is issued and popped
// when stall falls; the stall length of every operation is checked too.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam int STALL_CYCLES = W + 2;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  logic         clk = 1'b0;
  logic         Rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic         stall;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int   checks   = 0;
  int   failures = 0;
  res_t exp_q[$];
  res_t last_res;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .Rst  (Rst),
    .start(start),
    .op   (op),
    .SrcA (SrcA),
    .SrcB (SrcB),
    .stall(stall),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  // Behavioural reference built on the simulator's own 64-bit arithmetic.
  function automatic res_t model(input logic [2:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    res_t        res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0;
    case (o)
      3'b000: begin p = sa * sb; res = p; end
      3'b001: begin p = {32'h0, a} * {32'h0, b}; res = p; end
      3'b010: begin
        if (b == '0) begin
          res.hi = a; res.lo = '1;
        end else begin
          q = sa / sb; r = sa % sb;
          res.hi = r[31:0]; res.lo = q[31:0];
        end
      end
      default: begin
        if (b == '0) begin
          res.hi = a; res.lo = '1;
        end else begin
          res.hi = a % b; res.lo = a / b;
        end
      end
    endcase
    return res;
  endfunction

  // Issues one mult/div, holds start until stall falls, and checks stall
  // length and result in the first DONE cycle. Leaves start high in DONE.
  task automatic run_op(input string name, input logic [2:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input res_t expv, input bit scramble);
    int   n;
    res_t e;
    @(negedge clk);
    start = 1'b1; op = o; SrcA = a; SrcB = b;
    exp_q.push_back(expv);
    #1;
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      if (scramble) begin
        SrcA = $urandom;
        SrcB = $urandom;
        op   = 3'($urandom_range(0, 5));
      end
      #1;
    end
    checks++;
    if (n !== STALL_CYCLES) begin
      failures++;
      $display("FAIL %s stall_len: got %0d expected %0d", name, n, STALL_CYCLES);
    end
    e = exp_q.pop_front();
    checks++;
    if (hi !== e.hi) begin
      failures++;
      $display("FAIL %s hi: got %h expected %h", name, hi, e.hi);
    end
    checks++;
    if (lo !== e.lo) begin
      failures++;
      $display("FAIL %s lo: got %h expected %h", name, lo, e.lo);
    end
    last_res = e;
  endtask

  // After DONE: start stays high into IDLE with a no-op code, then drops.
  // stall must stay low (nothing re-accepted) and HI/LO must hold.
  task automatic idle_check(input string name);
    @(negedge clk);
    start = 1'b1; op = 3'b110; SrcA = $urandom; SrcB = $urandom;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_stall: got %b expected 0", name, stall);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if ({hi, lo} !== last_res) begin
      failures++;
      $display("FAIL %s hold: got %h_%h expected %h_%h", name, hi, lo,
               last_res.hi, last_res.lo);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; start = 1'b0; op = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({stall, hi, lo} !== {1'b0, 64'h0}) begin
      failures++;
      $display("FAIL reset: got stall=%b hi=%h lo=%h expected 0/0/0", stall, hi, lo);
    end
    Rst = 1'b0;
  endtask

  task automatic test_multu_full();
    run_op("multu_ff", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF,
           {32'hFFFFFFFE, 32'h00000001}, 1'b0);
    idle_check("multu_ff");
  endtask

  task automatic test_mult_signed();
    run_op("mult_neg", 3'b000, 32'hFFFFFFFD, 32'h00000007,
           {32'hFFFFFFFF, 32'hFFFFFFEB}, 1'b0);
    idle_check("mult_neg");
    run_op("multu_same", 3'b001, 32'hFFFFFFFD, 32'h00000007,
           {32'h00000006, 32'hFFFFFFEB}, 1'b0);
    idle_check("multu_same");
  endtask

  task automatic test_div();
    run_op("div_neg", 3'b010, 32'hFFFFFFF9, 32'h00000002,
           {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);
    idle_check("div_neg");
    run_op("divu", 3'b011, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    idle_check("divu");
  endtask

  task automatic test_div_edges();
    run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF,
           {32'h00000000, 32'h80000000}, 1'b0);
    idle_check("div_ovf");
    run_op("divu_zero", 3'b011, 32'h00001234, 32'h0,
           {32'h00001234, 32'hFFFFFFFF}, 1'b0);
    idle_check("divu_zero");
    run_op("div_zero_neg", 3'b010, 32'hFFFFFF00, 32'h0,
           {32'hFFFFFF00, 32'hFFFFFFFF}, 1'b0);
    idle_check("div_zero_neg");
  endtask

  task automatic test_mthi_mtlo();
    logic [W-1:0] old_lo;
    old_lo = lo;
    @(negedge clk);
    start = 1'b1; op = 3'b100; SrcA = 32'hDEADBEEF; SrcB = 32'h5;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL mthi_stall: got %b expected 0", stall);
    end
    @(negedge clk);
    #1;
    checks++;
    if (hi !== 32'hDEADBEEF || lo !== old_lo) begin
      failures++;
      $display("FAIL mthi: got hi=%h lo=%h expected %h %h", hi, lo, 32'hDEADBEEF, old_lo);
    end
    op = 3'b101; SrcA = 32'h0BADF00D;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL mtlo_stall: got %b expected 0", stall);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (hi !== 32'hDEADBEEF || lo !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL mtlo: got hi=%h lo=%h expected deadbeef 0badf00d", hi, lo);
    end
  endtask

  task automatic test_rst_abort();
    @(negedge clk);
    start = 1'b1; op = 3'b000; SrcA = 32'h12345678; SrcB = 32'h9ABCDEF0;
    repeat (10) @(negedge clk);
    Rst = 1'b1; start = 1'b0;
    @(negedge clk);
    Rst = 1'b0;
    #1;
    checks++;
    if ({stall, hi, lo} !== {1'b0, 64'h0}) begin
      failures++;
      $display("FAIL rst_abort: got stall=%b hi=%h lo=%h expected 0/0/0", stall, hi, lo);
    end
    // A fresh operation must run its full length from IDLE.
    run_op("after_abort", 3'b011, 32'd1000, 32'd33, {32'd10, 32'd30}, 1'b0);
    idle_check("after_abort");
  endtask

  task automatic test_operand_change();
    run_op("scramble_mult", 3'b000, 32'h00012345, 32'hFFFFFF80,
           model(3'b000, 32'h00012345, 32'hFFFFFF80), 1'b1);
    idle_check("scramble_mult");
    run_op("scramble_div", 3'b010, 32'h7FFFFFFF, 32'hFFFFFFF0,
           model(3'b010, 32'h7FFFFFFF, 32'hFFFFFFF0), 1'b1);
    idle_check("scramble_div");
  endtask

  task automatic test_back_to_back();
    logic [2:0]   o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 8; i++) begin
      o = 3'(i % 4);
      a = $urandom;
      b = (i == 5) ? 32'h0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      run_op("b2b", o, a, b, model(o, a, b), 1'b0);
    end
    idle_check("b2b");
  endtask

  initial begin
    test_reset();
    test_multu_full();
    test_mult_signed();
    test_div();
    test_div_edges();
    test_mthi_mtlo();
    test_rst_abort();
    test_operand_change();
    test_back_to_back();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_empty: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
